// File: rtl/vip_stream_pkg.sv
// Shared types and constants for VIP stream consumers.
package vip_stream_pkg;

  localparam int unsigned PIX_W = 24;

  typedef enum logic [1:0] {
    IDLE,
    ARMED,
    CAPTURE
  } cap_state_e;

  // True when a pixel RAM of 2^addr_w entries can hold a whole frame.
  function automatic bit addr_w_fits(input int unsigned addr_w, input int unsigned hdisp,
                                     input int unsigned vdisp);
    return (64'd1 << addr_w) >= (64'(hdisp) * 64'(vdisp));
  endfunction

endpackage

// File: rtl/vip_sync_edge_det.sv
// Registers vsync/href and flags frame start, frame end and line end.
module vip_sync_edge_det (
  input  logic clk,
  input  logic rst,
  input  logic vsync,
  input  logic href,
  output logic vs_rise,
  output logic vs_fall,
  output logic line_end
);

  logic vsync_d;
  logic href_d;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      vsync_d <= 1'b0;
      href_d  <= 1'b0;
    end else begin
      vsync_d <= vsync;
      href_d  <= href;
    end
  end

  assign vs_rise  = vsync & ~vsync_d;
  assign vs_fall  = ~vsync & vsync_d;
  assign line_end = ~href & href_d;

endmodule

// File: rtl/vip_frame_capture.sv
// Captures one complete VIP frame into an external pixel RAM and checks its geometry.
module vip_frame_capture
  import vip_stream_pkg::*;
#(
  parameter int unsigned IMG_HDISP = 400,
  parameter int unsigned IMG_VDISP = 400,
  parameter int unsigned ADDR_W    = 18
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              cap_start,
  input  logic              cap_abort,
  input  logic              pre_frame_vsync,
  input  logic              pre_frame_href,
  input  logic              pre_frame_clken,
  input  logic [PIX_W-1:0]  pre_img_data,
  output logic              wr_en,
  output logic [ADDR_W-1:0] wr_addr,
  output logic [PIX_W-1:0]  wr_data,
  output logic              cap_busy,
  output logic              cap_done,
  output logic              err_hlen,
  output logic              err_vlen,
  output logic [15:0]       frame_cnt
);

  if (!addr_w_fits(ADDR_W, IMG_HDISP, IMG_VDISP)) begin : gen_addr_w_check
    $error("ADDR_W too small for IMG_HDISP*IMG_VDISP");
  end

  localparam logic [15:0]       HDISP16 = 16'(IMG_HDISP);
  localparam logic [15:0]       VDISP16 = 16'(IMG_VDISP);
  localparam logic [ADDR_W-1:0] HSTEP   = ADDR_W'(IMG_HDISP);

  cap_state_e        state_q;
  logic [15:0]       x_q, y_q;
  logic [ADDR_W-1:0] addr_q, row_q;
  logic              vs_rise, vs_fall, line_end;

  vip_sync_edge_det u_edge (
    .clk      (clk),
    .rst      (rst),
    .vsync    (pre_frame_vsync),
    .href     (pre_frame_href),
    .vs_rise  (vs_rise),
    .vs_fall  (vs_fall),
    .line_end (line_end)
  );

  logic              pix_take, in_range;
  logic [15:0]       x_inc, y_inc, y_next;
  logic [ADDR_W-1:0] row_next;

  assign pix_take = pre_frame_href & pre_frame_clken;
  assign in_range = (x_q < HDISP16) && (y_q < VDISP16);
  assign x_inc    = (x_q == 16'hFFFF) ? x_q : x_q + 16'd1;
  assign y_inc    = (y_q == 16'hFFFF) ? y_q : y_q + 16'd1;
  // Frame check sees the line count after any coincident line end.
  assign y_next   = line_end ? y_inc : y_q;
  assign row_next = row_q + HSTEP;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= IDLE;
      x_q       <= '0;
      y_q       <= '0;
      addr_q    <= '0;
      row_q     <= '0;
      wr_en     <= 1'b0;
      wr_addr   <= '0;
      wr_data   <= '0;
      cap_busy  <= 1'b0;
      cap_done  <= 1'b0;
      err_hlen  <= 1'b0;
      err_vlen  <= 1'b0;
      frame_cnt <= '0;
    end else begin
      wr_en    <= 1'b0;
      cap_done <= 1'b0;
      if (vs_rise) frame_cnt <= frame_cnt + 16'd1;

      unique case (state_q)
        IDLE: begin
          if (cap_start) begin
            state_q  <= ARMED;
            cap_busy <= 1'b1;
            err_hlen <= 1'b0;
            err_vlen <= 1'b0;
            x_q      <= '0;
            y_q      <= '0;
            addr_q   <= '0;
            row_q    <= '0;
          end
        end
        ARMED: begin
          if (cap_abort) begin
            state_q  <= IDLE;
            cap_busy <= 1'b0;
          end else if (vs_rise) begin
            state_q <= CAPTURE;
          end
        end
        CAPTURE: begin
          if (cap_abort) begin
            state_q  <= IDLE;
            cap_busy <= 1'b0;
          end else begin
            if (pix_take) begin
              if (in_range) begin
                wr_en   <= 1'b1;
                wr_data <= pre_img_data;
                wr_addr <= addr_q;
                addr_q  <= addr_q + 1'b1;
              end
              x_q <= x_inc;
            end
            if (line_end) begin
              if (x_q != HDISP16) err_hlen <= 1'b1;
              y_q    <= y_inc;
              x_q    <= '0;
              row_q  <= row_next;
              addr_q <= row_next;
            end
            if (vs_fall) begin
              if (y_next != VDISP16) err_vlen <= 1'b1;
              cap_done <= 1'b1;
              cap_busy <= 1'b0;
              state_q  <= IDLE;
            end
          end
        end
        default: begin
          state_q  <= IDLE;
          cap_busy <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_vip_frame_capture.sv
// Scoreboard bench for vip_frame_capture on a 4x3 frame.
module tb_vip_frame_capture;

  localparam int unsigned H  = 4;
  localparam int unsigned V  = 3;
  localparam int unsigned AW = 4;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          cap_start = 1'b0;
  logic          cap_abort = 1'b0;
  logic          vsync = 1'b0;
  logic          href = 1'b0;
  logic          clken = 1'b0;
  logic [23:0]   data = '0;
  logic          wr_en;
  logic [AW-1:0] wr_addr;
  logic [23:0]   wr_data;
  logic          cap_busy, cap_done, err_hlen, err_vlen;
  logic [15:0]   frame_cnt;

  typedef struct {
    logic [AW-1:0] addr;
    logic [23:0]   data;
    int            cyc;
  } wr_t;

  wr_t exp_q[$];
  wr_t mon_e;
  int  checks = 0;
  int  errors = 0;
  int  done_cnt = 0;
  int  cyc = 0;
  int  fc_model = 0;
  int  line_len [0:7];

  vip_frame_capture #(
    .IMG_HDISP (H),
    .IMG_VDISP (V),
    .ADDR_W    (AW)
  ) dut (
    .clk             (clk),
    .rst             (rst),
    .cap_start       (cap_start),
    .cap_abort       (cap_abort),
    .pre_frame_vsync (vsync),
    .pre_frame_href  (href),
    .pre_frame_clken (clken),
    .pre_img_data    (data),
    .wr_en           (wr_en),
    .wr_addr         (wr_addr),
    .wr_data         (wr_data),
    .cap_busy        (cap_busy),
    .cap_done        (cap_done),
    .err_hlen        (err_hlen),
    .err_vlen        (err_vlen),
    .frame_cnt       (frame_cnt)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // Every write must match the oldest expected pixel, one cycle after it was driven.
  always @(negedge clk) begin
    if (wr_en) begin
      checks++;
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL unexpected_write: got addr=%0d data=%h, required no write", wr_addr, wr_data);
      end else begin
        mon_e = exp_q.pop_front();
        if (wr_addr !== mon_e.addr || wr_data !== mon_e.data || cyc != mon_e.cyc + 1) begin
          errors++;
          $display("FAIL write: got addr=%0d data=%h cyc=%0d, required addr=%0d data=%h cyc=%0d",
                   wr_addr, wr_data, cyc, mon_e.addr, mon_e.data, mon_e.cyc + 1);
        end
      end
    end
    if (cap_done) done_cnt++;
  end

  task automatic push(input int l, input int p, input logic [23:0] d);
    exp_q.push_back('{addr: AW'(l * H + p), data: d, cyc: cyc});
  endtask

  task automatic arm();
    cap_start = 1'b1;
    @(negedge clk);
    cap_start = 1'b0;
    @(negedge clk);
  endtask

  task automatic check_drained(input string name);
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL %s_missing_writes: got %0d pending, required 0", name, exp_q.size());
      exp_q.delete();
    end
  endtask

  // One frame: per-line lengths from line_len; optional cap_start pulse at the start of arm_line.
  task automatic send_frame(input int nlines, input bit exp_wr, input bit gapped, input int arm_line,
                            input bit exp_done, input bit exp_h, input bit exp_v, input int tag,
                            input string name);
    logic [23:0] d;
    vsync = 1'b1;
    fc_model++;
    repeat (2) @(negedge clk);
    for (int l = 0; l < nlines; l++) begin
      href = 1'b1;
      for (int p = 0; p < line_len[l]; p++) begin
        d = 24'(tag * 256 + l * 16 + p);
        cap_start = (l == arm_line && p == 0);
        clken = 1'b1;
        data = d;
        if (exp_wr && p < int'(H) && l < int'(V)) push(l, p, d);
        @(negedge clk);
        cap_start = 1'b0;
        if (gapped) begin
          clken = 1'b0;
          data = 24'hABCDEF;
          @(negedge clk);
        end
      end
      href = 1'b0;
      clken = 1'b0;
      repeat (2) @(negedge clk);
    end
    vsync = 1'b0;
    @(negedge clk);
    checks++;
    if (cap_done !== exp_done) begin
      errors++;
      $display("FAIL %s_done: got %b, required %b", name, cap_done, exp_done);
    end
    if (exp_done) begin
      checks++;
      if (cap_busy !== 1'b0 || err_hlen !== exp_h || err_vlen !== exp_v) begin
        errors++;
        $display("FAIL %s_flags: got busy=%b hlen=%b vlen=%b, required busy=0 hlen=%b vlen=%b",
                 name, cap_busy, err_hlen, err_vlen, exp_h, exp_v);
      end
    end
    checks++;
    if (frame_cnt !== 16'(fc_model)) begin
      errors++;
      $display("FAIL %s_frame_cnt: got %0d, required %0d", name, frame_cnt, fc_model);
    end
    @(negedge clk);
    checks++;
    if (cap_done !== 1'b0) begin
      errors++;
      $display("FAIL %s_done_width: got %b, required 0", name, cap_done);
    end
    repeat (2) @(negedge clk);
    check_drained(name);
  endtask

  task automatic set_lens(input int a, input int b, input int c, input int d);
    line_len[0] = a;
    line_len[1] = b;
    line_len[2] = c;
    line_len[3] = d;
  endtask

  task automatic test_reset();
    repeat (2) @(negedge clk);
    checks++;
    if ({wr_en, wr_addr, wr_data, cap_busy, cap_done, err_hlen, err_vlen, frame_cnt} !== '0) begin
      errors++;
      $display("FAIL reset_outputs: got wr_en=%b addr=%0d data=%h busy=%b done=%b fc=%0d, required 0",
               wr_en, wr_addr, wr_data, cap_busy, cap_done, frame_cnt);
    end
    rst = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_nominal();
    int d0;
    d0 = done_cnt;
    set_lens(4, 4, 4, 4);
    arm();
    checks++;
    if (cap_busy !== 1'b1) begin
      errors++;
      $display("FAIL nominal_busy_armed: got %b, required 1", cap_busy);
    end
    send_frame(3, 1, 0, -1, 1, 0, 0, 0, "nominal");
    checks++;
    if (done_cnt != d0 + 1) begin
      errors++;
      $display("FAIL nominal_done_count: got %0d, required %0d", done_cnt - d0, 1);
    end
  endtask

  task automatic test_mid_frame_arm();
    int d0;
    d0 = done_cnt;
    set_lens(4, 4, 4, 4);
    send_frame(3, 0, 0, 1, 0, 0, 0, 1, "midarm_a");
    send_frame(3, 1, 0, -1, 1, 0, 0, 2, "midarm_b");
    checks++;
    if (done_cnt != d0 + 1) begin
      errors++;
      $display("FAIL midarm_done_count: got %0d, required 1", done_cnt - d0);
    end
  endtask

  task automatic test_short_long();
    set_lens(4, 3, 5, 4);
    arm();
    send_frame(3, 1, 0, -1, 1, 1, 0, 3, "shortlong");
  endtask

  task automatic test_extra_lines();
    set_lens(4, 4, 4, 4);
    arm();
    send_frame(4, 1, 0, -1, 1, 0, 1, 4, "extra");
  endtask

  task automatic test_gapped();
    set_lens(4, 4, 4, 4);
    arm();
    send_frame(3, 1, 1, -1, 1, 0, 0, 5, "gapped");
  endtask

  task automatic test_abort();
    int d0;
    logic [23:0] d;
    d0 = done_cnt;
    arm();
    vsync = 1'b1;
    fc_model++;
    repeat (2) @(negedge clk);
    for (int l = 0; l < 2; l++) begin
      href = 1'b1;
      for (int p = 0; p < (l == 0 ? 4 : 1); p++) begin
        d = 24'(6 * 256 + l * 16 + p);
        clken = 1'b1;
        data = d;
        push(l, p, d);
        @(negedge clk);
      end
      href = 1'b0;
      clken = 1'b0;
      repeat (2) @(negedge clk);
    end
    check_drained("abort_prefix");
    cap_abort = 1'b1;
    @(negedge clk);
    cap_abort = 1'b0;
    checks++;
    if (cap_busy !== 1'b0) begin
      errors++;
      $display("FAIL abort_busy: got %b, required 0", cap_busy);
    end
    vsync = 1'b0;
    repeat (3) @(negedge clk);
    checks++;
    if (done_cnt != d0 || err_hlen !== 1'b1) begin
      errors++;
      $display("FAIL abort_no_done: got done=%0d hlen=%b, required done=0 hlen=1",
               done_cnt - d0, err_hlen);
    end
    set_lens(4, 4, 4, 4);
    arm();
    send_frame(3, 1, 0, -1, 1, 0, 0, 7, "abort_restart");
  endtask

  task automatic test_rst_mid_line();
    arm();
    vsync = 1'b1;
    fc_model++;
    repeat (2) @(negedge clk);
    href = 1'b1;
    for (int p = 0; p < 2; p++) begin
      clken = 1'b1;
      data = 24'(8 * 256 + p);
      push(0, p, data);
      @(negedge clk);
    end
    clken = 1'b0;
    repeat (2) @(negedge clk);
    rst = 1'b1;
    #1;
    checks++;
    if ({wr_en, wr_addr, wr_data, cap_busy, cap_done, err_hlen, err_vlen, frame_cnt} !== '0) begin
      errors++;
      $display("FAIL rst_mid_line: got wr_en=%b addr=%0d data=%h busy=%b fc=%0d, required 0",
               wr_en, wr_addr, wr_data, cap_busy, frame_cnt);
    end
    @(negedge clk);
    href = 1'b0;
    vsync = 1'b0;
    rst = 1'b0;
    fc_model = 0;
    repeat (2) @(negedge clk);
    checks++;
    if (cap_busy !== 1'b0 || frame_cnt !== 16'd0) begin
      errors++;
      $display("FAIL rst_after: got busy=%b fc=%0d, required busy=0 fc=0", cap_busy, frame_cnt);
    end
    check_drained("rst");
  endtask

  initial begin
    test_reset();
    test_nominal();
    test_mid_frame_arm();
    test_short_long();
    test_extra_lines();
    test_gapped();
    test_abort();
    test_rst_mid_line();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
